ram_wait_states: RTL and testbench

Parametrised single-port synchronous RAM with a req/ack handshake, a programmable number of wait states, and an independent registered debug read port. It is the next-generation memory block behind the processor's RAM bus (address, data in/out, RW). It lets the CPU model slow external memory at any width and depth, and exposes a second read port for observing memory contents (data_debug style) without disturbing the CPU access stream.

---
 rtl/ram_wait_states_if.sv | 23 ++
 rtl/ram_wait_states.sv | 122 ++++++++++++
 tb/tb_ram_wait_states.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_wait_states_if.sv
// RAM bus bundle: request/handshake from the master, read data and status from the RAM.
interface ram_wait_states_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;
  logic                  busy;

  modport master (
    output req, rw, address, data_in,
    input  data_out, ack, busy
  );

  modport slave (
    input  req, rw, address, data_in,
    output data_out, ack, busy
  );
endinterface

// File: rtl/ram_wait_states.sv
// Single-port synchronous RAM with req/ack handshake, programmable wait states,
// saturating access counters and an independent registered debug read port.
module ram_wait_states #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter string       INIT_FILE   = ""
) (
  input  logic                   clock,
  input  logic                   reset,
  ram_wait_states_if.slave       bus,
  input  logic [ADDR_WIDTH-1:0]  dbg_address,
  output logic [DATA_WIDTH-1:0]  dbg_data,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic [COUNT_WIDTH-1:0] write_count
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  commit;
  logic                  acc_rw;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] data_out_q;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Next-state logic: accept in idle, count down wait states, single-cycle ack.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          accept  = 1'b1;
          wait_d  = WaitLoad;
          state_d = (WAIT_STATES > 0) ? StWait : StAck;
        end
      end
      StWait: begin
        if (wait_q == 4'd0) begin
          state_d = StAck;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // With zero wait states the access commits on the accept edge itself, so the
    // live inputs are used instead of the not-yet-latched copies.
    commit    = (state_d == StAck) && !reset;
    acc_rw    = accept ? bus.rw      : rw_q;
    acc_addr  = accept ? bus.address : addr_q;
    acc_wdata = accept ? bus.data_in : wdata_q;
  end

  // FSM state, wait counter and latched request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        rw_q    <= bus.rw;
        addr_q  <= bus.address;
        wdata_q <= bus.data_in;
      end
    end
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge clock) begin
    if (commit && acc_rw) begin
      mem[acc_addr] <= wdata_q_sel();
    end
  end

  function automatic logic [DATA_WIDTH-1:0] wdata_q_sel();
    return acc_wdata;
  endfunction

  // Read data, debug port and saturating counters; debug read sees the pre-write word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q  <= '0;
      dbg_data    <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      dbg_data <= mem[dbg_address];
      if (commit) begin
        if (acc_rw) begin
          if (write_count != '1) write_count <= write_count + COUNT_WIDTH'(1);
        end else begin
          data_out_q <= mem[acc_addr];
          if (read_count != '1) read_count <= read_count + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.ack      = (state_q == StAck);

endmodule

// File: tb/tb_ram_wait_states.sv
// Randomized self-checking bench for ram_wait_states against a cycle-count reference model.
module tb_ram_wait_states;
  localparam int W = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ram_wait_states_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_a ();
  ram_wait_states_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus_b ();

  logic [7:0]  dbg_a, dbg_b;
  logic [15:0] dbg_data_a, dbg_data_b;
  logic [3:0]  rd_a, wr_a, rd_b, wr_b;

  ram_wait_states #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(W), .COUNT_WIDTH(4), .INIT_FILE("")
  ) u_dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave), .dbg_address(dbg_a),
    .dbg_data(dbg_data_a), .read_count(rd_a), .write_count(wr_a)
  );

  ram_wait_states #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(0), .COUNT_WIDTH(4), .INIT_FILE("")
  ) u_dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave), .dbg_address(dbg_b),
    .dbg_data(dbg_data_b), .read_count(rd_b), .write_count(wr_b)
  );

  // Reference model state.
  logic [15:0] mem_m [256];
  bit          valid_m [256];
  int          rd_m, wr_m;
  logic [15:0] dout_m;
  bit          dbg_rand;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; apply the model's commit on this edge and check the debug port.
  task automatic tick(input bit commit, input bit c_rw, input logic [7:0] c_addr,
                      input logic [15:0] c_data);
    logic [15:0] exp_dbg;
    bit          ev;
    ev      = valid_m[dbg_a];
    exp_dbg = mem_m[dbg_a];
    @(posedge clock);
    if (commit) begin
      if (c_rw) begin
        mem_m[c_addr]   = c_data;
        valid_m[c_addr] = 1'b1;
        if (wr_m < 15) wr_m++;
      end else begin
        dout_m = mem_m[c_addr];
        if (rd_m < 15) rd_m++;
      end
    end
    @(negedge clock);
    if (ev) check("dbg_data", dbg_data_a, exp_dbg);
    if (dbg_rand) dbg_a = 8'($urandom_range(0, 15));
  endtask

  // One access on DUT A starting in idle; checks every cycle up to the following idle cycle.
  task automatic access(input bit wr, input logic [7:0] addr, input logic [15:0] data,
                        input bit hold);
    bus_a.req     = 1'b1;
    bus_a.rw      = wr;
    bus_a.address = addr;
    bus_a.data_in = data;
    for (int j = 0; j <= W + 1; j++) begin
      tick(j == W, wr, addr, data);
      if (!hold) bus_a.req = 1'b0;
      // Inputs after acceptance must have no effect.
      bus_a.rw      = 1'($urandom);
      bus_a.address = 8'($urandom);
      bus_a.data_in = 16'($urandom);
      if (j <= W) begin
        check("busy_in_flight", bus_a.busy, 1);
        check("ack_timing", bus_a.ack, (j == W) ? 1 : 0);
      end else begin
        check("busy_idle", bus_a.busy, 0);
        check("ack_idle", bus_a.ack, 0);
      end
      check("data_out", bus_a.data_out, dout_m);
      check("read_count", rd_a, rd_m);
      check("write_count", wr_a, wr_m);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    bit         w;
    reset = 1'b1;
    bus_a.req = 1'b0; bus_a.rw = 1'b0; bus_a.address = '0; bus_a.data_in = '0;
    bus_b.req = 1'b0; bus_b.rw = 1'b0; bus_b.address = '0; bus_b.data_in = '0;
    dbg_a = '0; dbg_b = '0; dbg_rand = 1'b0;
    rd_m = 0; wr_m = 0; dout_m = '0;
    for (int i = 0; i < 256; i++) begin
      valid_m[i] = 1'b0;
      mem_m[i]   = '0;
    end
    repeat (2) @(negedge clock);
    check("rst_busy", bus_a.busy, 0);
    check("rst_ack", bus_a.ack, 0);
    check("rst_data_out", bus_a.data_out, 0);
    check("rst_dbg", dbg_data_a, 0);
    check("rst_rd", rd_a, 0);
    check("rst_wr", wr_a, 0);
    reset = 1'b0;
    @(negedge clock);

    // Write / read back.
    access(1'b1, 8'h12, 16'hBEEF, 1'b0);
    access(1'b0, 8'h12, 16'h0000, 1'b0);
    check("rb_data", bus_a.data_out, 16'hBEEF);
    check("rb_wr_cnt", wr_a, 1);
    check("rb_rd_cnt", rd_a, 1);

    // Debug/write collision returns the old word first.
    access(1'b1, 8'h40, 16'h1111, 1'b0);
    dbg_a = 8'h40;
    access(1'b1, 8'h40, 16'h5555, 1'b0);

    // Continuous req with alternating addresses: only one accept per W+2 cycles.
    for (int i = 0; i < 6; i++) begin
      access((i == 0) || (i == 1) || (i == 4), (i % 2 == 0) ? 8'h20 : 8'h21,
             16'(16'hC000 + i), i < 5);
    end

    // Reset during the wait state aborts the pending write.
    access(1'b1, 8'h07, 16'h0001, 1'b0);
    bus_a.req = 1'b1; bus_a.rw = 1'b1; bus_a.address = 8'h07; bus_a.data_in = 16'hAAAA;
    tick(1'b0, 1'b1, 8'h07, 16'hAAAA);
    bus_a.req = 1'b0;
    check("pre_rst_busy", bus_a.busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", bus_a.busy, 0);
    check("mid_rst_ack", bus_a.ack, 0);
    check("mid_rst_rd", rd_a, 0);
    check("mid_rst_wr", wr_a, 0);
    check("mid_rst_dout", bus_a.data_out, 0);
    rd_m = 0; wr_m = 0; dout_m = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    access(1'b0, 8'h07, 16'h0000, 1'b0);
    check("rst_no_commit", bus_a.data_out, 16'h0001);

    // Counter saturation.
    repeat (17) access(1'b0, 8'h07, 16'h0000, 1'b0);
    check("rd_saturate", rd_a, 15);

    // Randomized traffic with random debug addresses.
    dbg_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 15));
      w = 1'($urandom) || !valid_m[a];
      access(w, a, 16'($urandom), (i < 39) ? 1'($urandom) : 1'b0);
    end
    dbg_rand = 1'b0;

    // Zero wait-state configuration.
    bus_b.req = 1'b1; bus_b.rw = 1'b1; bus_b.address = 8'h00; bus_b.data_in = 16'h1234;
    @(posedge clock);
    @(negedge clock);
    check("z_ack1", bus_b.ack, 1);
    check("z_busy1", bus_b.busy, 1);
    check("z_dout_write", bus_b.data_out, 0);
    bus_b.rw = 1'b0; bus_b.data_in = 16'h0000;
    @(negedge clock);
    check("z_ack_gap", bus_b.ack, 0);
    check("z_busy_gap", bus_b.busy, 0);
    @(negedge clock);
    check("z_ack2", bus_b.ack, 1);
    check("z_read", bus_b.data_out, 16'h1234);
    check("z_counts", {wr_b, rd_b}, 8'h11);
    bus_b.req = 1'b0;
    @(negedge clock);
    check("z_ack_end", bus_b.ack, 0);
    check("z_dbg", dbg_data_b, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
